cdc_handshake_tx: RTL and testbench

- Source-domain end of a four-phase req/ack clock-domain crossing for multi-bit words.
- Accepts a word on a valid/ready interface in the clk domain and holds it stable on tx_data.
- Drives tx_req to the remote domain and synchronizes the remote tx_ack_async back into clk.
- Complements the edge/pulse synchronizers already used on the receive side; the remote receiver samples tx_data once its synchronized req is high.

---
 rtl/cdc_handshake_tx.sv | 121 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Source end of a four-phase req/ack crossing for multi-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_req,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ack_async,
   output logic              done_pulse,
   input  logic              err_clr,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  tx_count
);

   localparam int c_TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_TO_W-1:0] c_TO_FULL = c_TO_W'(TIMEOUT);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [c_TO_W-1:0]      r_to_cnt;

   logic w_ack_s;
   logic w_ready;
   logic w_wait_state;
   logic w_leave;
   logic w_to_hit;

   // Only the last synchronizer stage is ever observed by the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], tx_ack_async};
      end
   end

   assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
   assign w_ready      = (r_state == IDLE) && !w_ack_s;
   assign in_ready     = w_ready;
   assign w_wait_state = (r_state == REQ) || (r_state == RELEASE);
   assign w_leave      = ((r_state == REQ) && w_ack_s) || ((r_state == RELEASE) && !w_ack_s);
   // The flag is set on the cycle the counter reaches its limit, not while it sits saturated.
   assign w_to_hit     = (TIMEOUT != 0) && w_wait_state && !w_leave && (r_to_cnt == c_TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         tx_req      <= 1'b0;
         tx_data     <= '0;
         done_pulse  <= 1'b0;
         tx_count    <= '0;
         r_to_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         done_pulse <= 1'b0;

         case (r_state)
            IDLE: begin
               if (in_valid && w_ready) begin
                  tx_data <= in_data;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               tx_req  <= 1'b1;
               r_state <= REQ;
            end
            REQ: begin
               if (w_ack_s) begin
                  tx_req  <= 1'b0;
                  r_state <= RELEASE;
               end
            end
            RELEASE: begin
               if (!w_ack_s) begin
                  r_state    <= IDLE;
                  done_pulse <= 1'b1;
                  tx_count   <= tx_count + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (!w_wait_state || w_leave) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != c_TO_FULL) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
         end

         if (w_to_hit) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Directed + randomized bench with a remote receiver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 16;
   localparam int CNT_W       = 4;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data  = '0;
   logic              err_clr  = 1'b0;
   logic              in_ready;
   logic              tx_req;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ack_async;
   logic              done_pulse;
   logic              timeout_err;
   logic [CNT_W-1:0]  tx_count;

   logic remote_ack  = 1'b0;
   logic force_hi    = 1'b0;
   logic remote_en   = 1'b0;
   logic remote_hold = 1'b0;
   int   remote_dly  = 3;
   int   rcnt        = 0;
   int   recv_n      = 0;
   int   recv_chk    = 0;
   logic [DATA_W-1:0] recv_mem [0:63];

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] last_word = '0;
   logic              prev_req  = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   assign tx_ack_async = remote_ack | force_hi;

   always #5 clk = ~clk;

   cdc_handshake_tx #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .tx_req       (tx_req),
      .tx_data      (tx_data),
      .tx_ack_async (tx_ack_async),
      .done_pulse   (done_pulse),
      .err_clr      (err_clr),
      .timeout_err  (timeout_err),
      .tx_count     (tx_count)
   );

   // Remote receiver: acks remote_dly edges after seeing req, drops ack likewise after req falls.
   always @(posedge clk) begin
      if (!remote_en) begin
         rcnt       <= 0;
         remote_ack <= 1'b0;
      end else if ((tx_req != remote_ack) && !(remote_hold && remote_ack)) begin
         if (rcnt >= remote_dly - 1) begin
            remote_ack <= tx_req;
            rcnt       <= 0;
            if (tx_req && recv_n < 64) begin
               recv_mem[recv_n] <= tx_data;
               recv_n           <= recv_n + 1;
            end
         end else begin
            rcnt <= rcnt + 1;
         end
      end else begin
         rcnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // The held word must not move while the request is up.
   always @(negedge clk) begin
      if (!reset && tx_req && prev_req)
         chk("data_stable_req", 32'(tx_data), 32'(prev_data));
      prev_req  <= tx_req;
      prev_data <= tx_data;
   end

   task automatic check_recv(input int n);
      logic [31:0] obs;
      for (int i = 0; i < n; i++) begin
         obs = (recv_chk < recv_n) ? 32'(recv_mem[recv_chk]) : 32'hDEAD_BEEF;
         if (exp_q.size() > 0) chk("recv_word", obs, 32'(exp_q.pop_front()));
         else chk("recv_expected", 32'(exp_q.size()), 1);
         recv_chk++;
      end
   endtask

   // Called at a negedge; returns at the negedge where tx_req is first seen high.
   task automatic send_word(input logic [DATA_W-1:0] w);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_send", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom);
      chk("tx_data_accept", 32'(tx_data), 32'(w));
      chk("ready_low_load", 32'(in_ready), 0);
      chk("req_low_load", 32'(tx_req), 0);
      @(negedge clk);
      chk("req_high_after_accept", 32'(tx_req), 1);
      exp_q.push_back(w);
      last_word = w;
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (!done_pulse && t < 200) begin
         if (in_ready) chk("ready_low_busy", 32'(in_ready), 0);
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(done_pulse), 1);
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      chk("count_after_done", 32'(tx_count), 32'(exp_cnt));
      chk("ready_on_done", 32'(in_ready), 1);
      check_recv(1);
   endtask

   initial begin
      logic [DATA_W-1:0] words [0:2];
      int idx;
      int dones;
      int t;
      logic fire;

      repeat (3) @(negedge clk);
      chk("rst_req", 32'(tx_req), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_done", 32'(done_pulse), 0);
      chk("rst_err", 32'(timeout_err), 0);
      chk("rst_count", 32'(tx_count), 0);
      reset     = 1'b0;
      remote_en = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(in_ready), 1);

      // Single transfer
      remote_dly = 3;
      send_word(8'hA5);
      wait_done("done_single");
      @(negedge clk);
      chk("done_one_cycle", 32'(done_pulse), 0);
      chk("data_held_after", 32'(tx_data), 32'hA5);

      // Back-to-back with in_valid held high
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
      idx = 0; dones = 0; t = 0;
      in_valid = 1'b1;
      in_data  = words[0];
      while ((idx < 3 || dones < 3) && t < 400) begin
         fire = in_valid && in_ready;
         if (done_pulse) dones++;
         @(negedge clk);
         t++;
         if (fire) begin
            exp_q.push_back(in_data);
            idx++;
            if (idx < 3) in_data = words[idx];
            else in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      last_word = 8'h03;
      chk("b2b_accepts", 32'(idx), 3);
      chk("b2b_dones", 32'(dones), 3);
      exp_cnt = (exp_cnt + 3) % (1 << CNT_W);
      chk("b2b_count", 32'(tx_count), 32'(exp_cnt));
      chk("b2b_recv_n", 32'(recv_n - recv_chk), 3);
      check_recv(3);

      // Ack stuck high while idle
      force_hi = 1'b1;
      repeat (3) @(negedge clk);
      chk("forced_ready_low", 32'(in_ready), 0);
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (4) @(negedge clk);
      chk("forced_no_req", 32'(tx_req), 0);
      chk("forced_no_accept", 32'(tx_data), 32'(last_word));
      in_valid = 1'b0;
      force_hi = 1'b0;
      @(negedge clk);
      chk("release_ready_1cyc", 32'(in_ready), 0);
      @(negedge clk);
      chk("release_ready_2cyc", 32'(in_ready), 1);

      // Timeout in REQ, clear, then timeout in RELEASE with clear held (set wins)
      remote_en   = 1'b0;
      remote_hold = 1'b1;
      send_word(8'h3C);
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("to_req_early", 32'(timeout_err), 0);
      @(negedge clk);
      chk("to_req_set", 32'(timeout_err), 1);
      chk("to_req_still_req", 32'(tx_req), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_clear", 32'(timeout_err), 0);
      repeat (5) @(negedge clk);
      chk("to_stays_clear", 32'(timeout_err), 0);
      chk("to_req_held", 32'(tx_req), 1);
      remote_en = 1'b1;
      t = 0;
      while (tx_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("late_ack_req_drop", 32'(tx_req), 0);
      err_clr = 1'b1;
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("to_rel_early", 32'(timeout_err), 0);
      @(negedge clk);
      chk("to_rel_set_wins", 32'(timeout_err), 1);
      err_clr     = 1'b0;
      remote_hold = 1'b0;
      wait_done("done_after_timeout");
      chk("to_sticky", 32'(timeout_err), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_clear2", 32'(timeout_err), 0);

      // Reset while in REQ
      remote_dly = 5;
      send_word(8'h5A);
      #2 reset = 1'b1;
      #1;
      chk("midrst_req", 32'(tx_req), 0);
      chk("midrst_data", 32'(tx_data), 0);
      chk("midrst_count", 32'(tx_count), 0);
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 0;
      exp_q.delete();
      recv_chk = recv_n;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_ready", 32'(in_ready), 1);
      chk("midrst_count_after", 32'(tx_count), 0);

      // 17 random transfers: counter wraps
      for (int i = 0; i < 17; i++) begin
         remote_dly = int'($urandom_range(1, 5));
         send_word(DATA_W'($urandom));
         wait_done("done_rand");
      end
      chk("count_wrap", 32'(tx_count), 1);
      chk("no_spurious_err", 32'(timeout_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
